issue_queue_allocator: RTL and testbench
========================================

# issue_queue_allocator

Dispatch-side slot allocator for an issue queue. It owns the occupancy bitmap of a QUEUE_DEPTH-entry queue and hands the lowest-indexed free slot to rename/dispatch on each accepted request. It releases slots that the issue side reports as issued, and drives the registered occupancy vector into the issue-side `priority_decoder`'s `w_req_left` input. It is the writer half of the occupancy protocol whose reader half is `priority_decoder`.

## Interface
Parameters:
- QUEUE_DEPTH, default 8: number of queue slots. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low.
- flush  input  1  pipeline flush; clears every slot.
- dispatch_valid  input  1  dispatch wants a slot this cycle.
- dispatch_ready  output  1  a free slot exists; equals ~full.
- alloc_addr  output  $clog2(QUEUE_DEPTH)  index of the slot granted this cycle; valid when dispatch_ready.
- alloc_fire  output  1  dispatch_valid & dispatch_ready & ~flush; write enable for queue storage at alloc_addr.
- issue_free  input  QUEUE_DEPTH  multi-hot set of slots released by issue this cycle.
- occupied  output  QUEUE_DEPTH  registered occupancy bitmap; feeds `priority_decoder.w_req_left`.
- occ_count  output  $clog2(QUEUE_DEPTH)+1  registered number of occupied slots.
- full  output  1  occ_count == QUEUE_DEPTH.
- empty  output  1  occ_count == 0.

## Operation
- State: `occupied` register (QUEUE_DEPTH bits) and `occ_count` register.
- alloc_addr is combinational from the `occupied` register: the lowest index i with occupied[i]==0. If no slot is free, alloc_addr is 0 and dispatch_ready is 0.
- Next state, in priority order:
  - rst==0: occupied='0, occ_count=0.
  - flush==1: occupied='0, occ_count=0. Any dispatch and free in the same cycle are discarded, and alloc_fire is 0.
  - Otherwise:
    - occupied_next = (occupied & ~issue_free) | (alloc_fire ? onehot(alloc_addr) : '0).
    - occ_count_next = occ_count + alloc_fire − popcount(issue_free & occupied).
- Frees take effect next cycle. A slot freed in cycle N is not allocatable until cycle N+1, so there is no same-cycle bypass.
- Because alloc_addr always points at a slot with occupied==0, alloc and free can never target the same slot in one cycle.
- issue_free bits on unoccupied slots are ignored: they are masked before the popcount, so they cause no underflow.
- Multiple frees plus one alloc in the same cycle are legal.
- Arithmetic uses $clog2(QUEUE_DEPTH)+1 bits, so occ_count cannot wrap.
- Invariant, checked by a simulation assertion: occ_count == popcount(occupied).

## Timing
- Reset values: occupied='0, occ_count=0, empty=1, full=0, dispatch_ready=1, alloc_addr=0, alloc_fire=0 when dispatch_valid=0.
- Allocation has 0-cycle latency: the grant and address are combinational in the request cycle. The slot appears in `occupied` on the next edge.
- full, empty and dispatch_ready derive from registers only. There is no combinational path from issue_free to dispatch_ready.
- dispatch_valid to alloc_fire is the only combinational input-to-output path, apart from flush gating alloc_fire.
- Full boundary: at full with a simultaneous free, dispatch_ready stays 0 that cycle. The freed slot is granted the following cycle.
- Reset or flush mid-stream: the next cycle shows all slots free, and alloc_addr=0.

## Structure
- Add `IQ_DEPTH` and the slot-index typedef `iq_idx_t` (logic [$clog2(IQ_DEPTH)-1:0]) to `rv32i_types`. This block and `priority_decoder` share them.
- Sub-module `free_slot_finder`: a purely combinational lowest-zero priority encoder.
  - Input: occupancy vector.
  - Outputs: index and any_free.
- The top level holds the registers, the next-state logic and the popcount.

## Test plan
- Reset, then 8 consecutive dispatch_valid cycles with QUEUE_DEPTH=8:
  - alloc_addr runs 0..7 and alloc_fire=1 each cycle.
  - After the 8th edge: full=1, occupied=8'hFF, occ_count=8, dispatch_ready=0.
- From full, issue_free=8'h24 with dispatch_valid=1:
  - Same cycle: alloc_fire=0.
  - Next cycle: occupied=8'hDB, occ_count=6, alloc_addr=2, alloc_fire=1.
  - Following cycle: occupied=8'hDF.
- occupied=8'h0F with issue_free=8'hF1 (bits 4–7 unoccupied) and no dispatch:
  - Next cycle: occupied=8'h0E, occ_count=3, no underflow.
- occupied=8'h03 with dispatch_valid=1 and issue_free=8'h01:
  - alloc_addr=2.
  - Next cycle: occupied=8'h06, occ_count=2.
- flush=1 together with dispatch_valid=1 and occupied=8'h5A:
  - alloc_fire=0.
  - Next cycle: occupied=0, empty=1, alloc_addr=0.
  - The same check is repeated with rst=0 in place of flush.

Source files
------------

// File: rtl/issue_queue_allocator_pkg.sv
// Shared issue-queue sizing and slot-index type, used by this allocator and priority_decoder.
package rv32i_types;

  localparam int unsigned IQ_DEPTH = 8;

  typedef logic [$clog2(IQ_DEPTH)-1:0] iq_idx_t;

endpackage

// File: rtl/issue_queue_allocator_free_slot_finder.sv
// Lowest-zero priority encoder over the issue-queue occupancy vector.
module free_slot_finder
  import rv32i_types::*;
#(
  parameter int unsigned Depth = IQ_DEPTH
) (
  input  logic [Depth-1:0]         occ,
  output logic [$clog2(Depth)-1:0] idx,
  output logic                     any_free
);

  localparam int unsigned IdxW = $clog2(Depth);

  // Scan high to low so the last hit, the lowest free index, wins.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = int'(Depth) - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        idx      = IdxW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue_allocator.sv
// Issue-queue slot allocator: owns the occupancy bitmap, grants the lowest free slot to dispatch
// and releases slots reported issued.
module issue_queue_allocator
  import rv32i_types::*;
#(
  parameter int unsigned QUEUE_DEPTH = IQ_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           dispatch_valid,
  output logic                           dispatch_ready,
  output logic [$clog2(QUEUE_DEPTH)-1:0] alloc_addr,
  output logic                           alloc_fire,
  input  logic [QUEUE_DEPTH-1:0]         issue_free,
  output logic [QUEUE_DEPTH-1:0]         occupied,
  output logic [$clog2(QUEUE_DEPTH):0]   occ_count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned IdxW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  logic [QUEUE_DEPTH-1:0] occupied_q, occupied_d;
  logic [CntW-1:0]        occ_count_q, occ_count_d;
  logic [QUEUE_DEPTH-1:0] released;
  logic [QUEUE_DEPTH-1:0] alloc_onehot;
  logic [CntW-1:0]        freed_cnt;
  logic                   any_free;

  free_slot_finder #(
    .Depth(QUEUE_DEPTH)
  ) u_free_slot_finder (
    .occ     (occupied_q),
    .idx     (alloc_addr),
    .any_free(any_free)
  );

  assign full           = (occ_count_q == CntW'(QUEUE_DEPTH));
  assign empty          = (occ_count_q == '0);
  assign dispatch_ready = ~full;
  // Reset also suppresses the storage write, since the slot is discarded anyway.
  assign alloc_fire     = dispatch_valid & dispatch_ready & ~flush & rst;
  assign occupied       = occupied_q;
  assign occ_count      = occ_count_q;

  // Frees on unoccupied slots are masked so they cannot underflow the count.
  assign released     = occupied_q & issue_free;
  assign alloc_onehot = {{(QUEUE_DEPTH - 1){1'b0}}, alloc_fire} << alloc_addr;

  always_comb begin
    freed_cnt = '0;
    for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
      freed_cnt = freed_cnt + CntW'(released[i]);
    end
  end

  always_comb begin
    occupied_d  = (occupied_q & ~issue_free) | alloc_onehot;
    occ_count_d = occ_count_q + CntW'(alloc_fire) - freed_cnt;
    if (flush) begin
      occupied_d  = '0;
      occ_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occupied_q  <= '0;
      occ_count_q <= '0;
    end else begin
      occupied_q  <= occupied_d;
      occ_count_q <= occ_count_d;
    end
  end

  a_count_matches_bitmap: assert property (@(posedge clk) disable iff (!rst)
    occ_count_q == CntW'($countones(occupied_q)));

  a_ready_matches_finder: assert property (@(posedge clk) disable iff (!rst)
    any_free == dispatch_ready);

endmodule

// File: tb/tb_issue_queue_allocator.sv
// Self-checking bench for issue_queue_allocator: directed vector table plus randomized model run.
module tb_issue_queue_allocator;

  localparam int unsigned D = 8;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       dispatch_valid;
  logic       dispatch_ready;
  logic [2:0] alloc_addr;
  logic       alloc_fire;
  logic [7:0] issue_free;
  logic [7:0] occupied;
  logic [3:0] occ_count;
  logic       full;
  logic       empty;

  int checks;
  int failures;

  issue_queue_allocator #(
    .QUEUE_DEPTH(D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .dispatch_valid(dispatch_valid),
    .dispatch_ready(dispatch_ready),
    .alloc_addr    (alloc_addr),
    .alloc_fire    (alloc_fire),
    .issue_free    (issue_free),
    .occupied      (occupied),
    .occ_count     (occ_count),
    .full          (full),
    .empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       fl;
    logic       dv;
    logic [7:0] fr;
    logic [2:0] exp_addr;
    logic       exp_fire;
    logic       exp_ready;
    logic [7:0] exp_occ;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rn, input logic fl, input logic dv, input logic [7:0] fr,
                     input logic [2:0] a, input logic f, input logic r, input logic [7:0] o,
                     input logic [3:0] c);
    vec_t v;
    v.rst_n = rn; v.fl = fl; v.dv = dv; v.fr = fr;
    v.exp_addr = a; v.exp_fire = f; v.exp_ready = r; v.exp_occ = o; v.exp_cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check_regs(input string tag, input logic [7:0] o, input logic [3:0] c);
    check({tag, ".occupied"}, int'(occupied), int'(o));
    check({tag, ".occ_count"}, int'(occ_count), int'(c));
    check({tag, ".full"}, int'(full), int'(c == 4'd8));
    check({tag, ".empty"}, int'(empty), int'(c == 4'd0));
  endtask

  // Reference model: a plain array of busy flags per slot.
  bit busy[D];

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < int'(D); i++) n += int'(busy[i]);
    return n;
  endfunction

  function automatic int model_lowest_free();
    for (int i = 0; i < int'(D); i++) if (!busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_bitmap();
    logic [7:0] m = '0;
    for (int i = 0; i < int'(D); i++) m[i] = busy[i];
    return m;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    flush = 1'b0;
    dispatch_valid = 1'b0;
    issue_free = '0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset", 8'h00, 4'd0);
    check("reset.ready", int'(dispatch_ready), 1);
    check("reset.addr", int'(alloc_addr), 0);
    check("reset.fire", int'(alloc_fire), 0);

    for (int i = 0; i < 8; i++) add(1, 0, 1, 8'h00, 3'(i), 1, 1, 8'((1 << (i + 1)) - 1), 4'(i + 1));
    add(1, 0, 1, 8'h24, 3'd0, 0, 0, 8'hDB, 4'd6);
    add(1, 0, 1, 8'h00, 3'd2, 1, 1, 8'hDF, 4'd7);
    add(1, 0, 0, 8'hF0, 3'd5, 0, 1, 8'h0F, 4'd4);
    add(1, 0, 0, 8'hF1, 3'd4, 0, 1, 8'h0E, 4'd3);
    add(1, 0, 1, 8'h0C, 3'd0, 1, 1, 8'h03, 4'd2);
    add(1, 0, 1, 8'h01, 3'd2, 1, 1, 8'h06, 4'd2);
    add(1, 0, 1, 8'h00, 3'd0, 1, 1, 8'h07, 4'd3);
    add(1, 0, 1, 8'h00, 3'd3, 1, 1, 8'h0F, 4'd4);
    add(1, 0, 1, 8'h00, 3'd4, 1, 1, 8'h1F, 4'd5);
    add(1, 0, 1, 8'h00, 3'd5, 1, 1, 8'h3F, 4'd6);
    add(1, 0, 1, 8'h00, 3'd6, 1, 1, 8'h7F, 4'd7);
    add(1, 0, 0, 8'h25, 3'd7, 0, 1, 8'h5A, 4'd4);
    add(1, 1, 1, 8'h00, 3'd0, 0, 1, 8'h00, 4'd0);
    add(1, 0, 0, 8'h00, 3'd0, 0, 1, 8'h00, 4'd0);
    for (int i = 0; i < 7; i++) add(1, 0, 1, 8'h00, 3'(i), 1, 1, 8'((1 << (i + 1)) - 1), 4'(i + 1));
    add(1, 0, 0, 8'h25, 3'd7, 0, 1, 8'h5A, 4'd4);
    add(0, 0, 1, 8'h00, 3'd0, 0, 1, 8'h00, 4'd0);
    add(1, 0, 0, 8'h00, 3'd0, 0, 1, 8'h00, 4'd0);

    rst = 1'b1;
    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst_n;
      flush = vecs[k].fl;
      dispatch_valid = vecs[k].dv;
      issue_free = vecs[k].fr;
      #1;
      check($sformatf("vec%0d.addr", k), int'(alloc_addr), int'(vecs[k].exp_addr));
      check($sformatf("vec%0d.fire", k), int'(alloc_fire), int'(vecs[k].exp_fire));
      check($sformatf("vec%0d.ready", k), int'(dispatch_ready), int'(vecs[k].exp_ready));
      @(posedge clk);
      #1;
      check_regs($sformatf("vec%0d", k), vecs[k].exp_occ, vecs[k].exp_cnt);
    end

    // Randomized run against the slot-array model; bench state is empty at this point.
    for (int i = 0; i < int'(D); i++) busy[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int lf;
      bit fire;
      @(negedge clk);
      rst = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 29) == 0);
      dispatch_valid = ($urandom_range(0, 3) != 0);
      issue_free = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      #1;
      lf = model_lowest_free();
      fire = dispatch_valid && (lf >= 0) && !flush && rst;
      check("rnd.ready", int'(dispatch_ready), int'(lf >= 0));
      check("rnd.addr", int'(alloc_addr), (lf >= 0) ? lf : 0);
      check("rnd.fire", int'(alloc_fire), int'(fire));
      if (!rst || flush) begin
        for (int j = 0; j < int'(D); j++) busy[j] = 1'b0;
      end else begin
        for (int j = 0; j < int'(D); j++) if (issue_free[j]) busy[j] = 1'b0;
        if (fire) busy[lf] = 1'b1;
      end
      @(posedge clk);
      #1;
      check_regs("rnd", model_bitmap(), 4'(model_count()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
